// File: rtl/riscv_pkg.sv
// Shared RV32 encodings for the memory stage: Funct3 access sizes, ResultSrc
// selects and the memory-access FSM state type.
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] RS_ALU  = 2'b00;
  localparam logic [1:0] RS_LOAD = 2'b01;
  localparam logic [1:0] RS_PC4  = 2'b10;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_t;

  // funct3[1:0] carries the access size for both loads and stores
  function automatic logic is_half(input logic [2:0] funct3);
    return funct3[1:0] == 2'b01;
  endfunction

  function automatic logic is_word(input logic [2:0] funct3);
    return funct3[1:0] == 2'b10;
  endfunction

endpackage

// File: rtl/load_extend.sv
// Load lane select and sign/zero extension. Address bits below the access
// size are ignored, so a misaligned half/word reads the aligned lane.
module load_extend
  import riscv_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [2:0]  funct3,
  output logic [31:0] value
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr)
      2'b00:   byte_sel = rdata[7:0];
      2'b01:   byte_sel = rdata[15:8];
      2'b10:   byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    case (funct3)
      F3_B:    value = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    value = {{16{half_sel[15]}}, half_sel};
      F3_BU:   value = {24'h000000, byte_sel};
      F3_HU:   value = {16'h0000, half_sel};
      default: value = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// RV32 memory stage: valid/ready data bus, store lane steering, load extension
// and MEM/WB register. Optional misalignment trap: MEM_STAGE_MISALIGN_CHK_EN.
//
// state | meaning
// IDLE  | request issued combinationally from M; stores retire on ready
// WAIT  | load accepted, waiting for DRspValid to retire
module mem_stage
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        ValidM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic [31:0] PCPlus4M,
  input  logic [4:0]  RdM,
  input  logic        RegWriteM,
  input  logic        MemWriteM,
  input  logic [1:0]  ResultSrcM,
  input  logic [2:0]  Funct3M,
  output logic        DReqValid,
  input  logic        DReqReady,
  output logic        DReqWe,
  output logic [31:0] DAddr,
  output logic [31:0] DWData,
  output logic [3:0]  DWStrb,
  input  logic        DRspValid,
  input  logic [31:0] DRData,
  output logic        StallM,
  output logic        ValidW,
  output logic        RegWriteW,
  output logic [31:0] ALUResultW,
  output logic [31:0] ReadDataW,
  output logic [31:0] PCPlus4W,
  output logic [4:0]  RdW,
`ifdef MEM_STAGE_MISALIGN_CHK_EN
  output logic        MisalignW,
`endif
  output logic [1:0]  ResultSrcW
);

  mem_state_t  state;
  logic        memop;
  logic        misal;
  logic        req;
  logic        store_done;
  logic        load_done;
  logic        retire;
  logic [31:0] load_value;
  logic [3:0]  strb;
  logic [31:0] wdata;

  always_comb begin
    memop = ValidM && (MemWriteM || (ResultSrcM == RS_LOAD));
`ifdef MEM_STAGE_MISALIGN_CHK_EN
    misal = memop && ((is_half(Funct3M) && ALUResultM[0]) ||
                      (is_word(Funct3M) && (ALUResultM[1:0] != 2'b00)));
`else
    misal = 1'b0;
`endif
    req        = memop && !misal && (state == IDLE);
    store_done = req && MemWriteM && DReqReady;
    load_done  = (state == WAIT) && DRspValid;
    retire     = ValidM && (!memop || misal || store_done || load_done);
  end

  always_comb begin
    if (is_word(Funct3M)) begin
      strb  = 4'b1111;
      wdata = WriteDataM;
    end else if (is_half(Funct3M)) begin
      strb  = 4'b0011 << {ALUResultM[1], 1'b0};
      wdata = {2{WriteDataM[15:0]}};
    end else begin
      strb  = 4'b0001 << ALUResultM[1:0];
      wdata = {4{WriteDataM[7:0]}};
    end
  end

  // Bus and stall outputs are gated by reset so they read 0 while it is held
  always_comb begin
    DReqValid = req && reset;
    DReqWe    = DReqValid && MemWriteM;
    DAddr     = {ALUResultM[31:2], 2'b00};
    DWData    = wdata;
    DWStrb    = DReqWe ? strb : 4'b0000;
    StallM    = reset && memop && !misal && !store_done && !load_done;
  end

  load_extend u_load_extend (
    .rdata  (DRData),
    .addr   (ALUResultM[1:0]),
    .funct3 (Funct3M),
    .value  (load_value)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      ValidW     <= 1'b0;
      RegWriteW  <= 1'b0;
      ALUResultW <= '0;
      ReadDataW  <= '0;
      PCPlus4W   <= '0;
      RdW        <= '0;
      ResultSrcW <= RS_ALU;
`ifdef MEM_STAGE_MISALIGN_CHK_EN
      MisalignW  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (req && !MemWriteM && DReqReady) state <= WAIT;
        WAIT: if (DRspValid) state <= IDLE;
        default: state <= IDLE;
      endcase

      if (retire) begin
        ValidW     <= 1'b1;
        RegWriteW  <= RegWriteM && !misal;
        ALUResultW <= ALUResultM;
        ReadDataW  <= load_value;
        PCPlus4W   <= PCPlus4M;
        RdW        <= RdM;
        ResultSrcW <= ResultSrcM;
`ifdef MEM_STAGE_MISALIGN_CHK_EN
        MisalignW  <= misal;
`endif
      end else begin
        ValidW    <= 1'b0;
        RegWriteW <= 1'b0;
`ifdef MEM_STAGE_MISALIGN_CHK_EN
        MisalignW <= 1'b0;
`endif
      end
    end
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory stage of the 5-stage RISC-V pipeline. It consumes the EX/MEM pipeline register outputs from the execute stage and issues loads and stores on a valid/ready data-memory bus. It handles byte-lane steering and load sign/zero extension, and stalls the front of the pipeline while an access is outstanding. It registers the MEM/WB pipeline outputs for writeback.

## Interface
Parameters:
- none; widths fixed at RV32 (XLEN 32, 5-bit register index).

Ports:
- clk  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-low reset
- ValidM  in  1  an instruction occupies the M stage
- ALUResultM  in  32  effective address or ALU result
- WriteDataM  in  32  store data, unaligned in low bits
- PCPlus4M  in  32  return address for JAL/JALR
- RdM  in  5  destination register
- RegWriteM, MemWriteM  in  1 each  writeback enable; store
- ResultSrcM  in  2  00 ALU, 01 load, 10 PC+4
- Funct3M  in  3  access size/sign (000 B, 001 H, 010 W, 100 BU, 101 HU)
- DReqValid  out  1  bus request valid
- DReqReady  in  1  memory accepts request
- DReqWe  out  1  1 = write
- DAddr  out  32  word address (bits [1:0] = 0)
- DWData  out  32  lane-steered write data
- DWStrb  out  4  byte strobes; 0000 on reads
- DRspValid  in  1  read data valid
- DRData  in  32  read word
- StallM  out  1  hold PC, IF/ID, ID/EX, EX/MEM this cycle
- ValidW, RegWriteW  out  1 each  MEM/WB valid; writeback enable
- ALUResultW, ReadDataW, PCPlus4W  out  32 each  MEM/WB data
- RdW  out  5  MEM/WB destination
- ResultSrcW  out  2  MEM/WB result select
- MisalignW  out  1  misaligned access flag (only with MEM_STAGE_MISALIGN_CHK_EN)

## Operation
- Memory op in M: ValidM & (MemWriteM | ResultSrcM==01). All other valid instructions retire to MEM/WB at the next edge with no stall.
- FSM states:
  - IDLE: a memory op drives DReqValid=1 combinationally from M inputs. On DReqReady: a store retires this cycle and the FSM stays in IDLE; a load goes to WAIT. Without DReqReady, the FSM stays in IDLE with the request held stable.
  - WAIT: DReqValid=0. On DRspValid the load retires and the FSM goes to IDLE.
- StallM = memory op & !(store & DReqReady in IDLE) & !(state==WAIT & DRspValid).
- Any cycle in which M does not retire loads a bubble into MEM/WB: ValidW=0, RegWriteW=0, other W fields don't-care.
- Store steering:
  - SB: data replicated to all four lanes, strobe 0001<<addr[1:0].
  - SH: data replicated to both halves, strobe 0011<<{addr[1],0}.
  - SW: strobe 1111.
- Load: byte/half selected from DRData by ALUResultM[1:0], captured in WAIT. Sign-extended for 000/001, zero-extended for 100/101. Result is registered into ReadDataW.
- DRspValid while in IDLE is ignored.

## Timing
- Reset: FSM to IDLE. All W outputs, DReqValid, DReqWe, DWStrb, StallM and MisalignW are 0.
- Non-memory op and store with same-cycle ready: 1-cycle latency, no stall.
- Load: request cycle T, earliest response T+1, W outputs valid from edge T+2. StallM is high in cycles T..(response-1).
- DReqValid is never deasserted before DReqReady.
- Reset asserted mid-access aborts the access: no retire, and a late response is dropped.

## Configuration
- MEM_STAGE_MISALIGN_CHK_EN defined:
  - LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0, issues no bus request.
  - The access retires in 1 cycle with MisalignW=1, RegWriteW=0 and ValidW=1.
- Undefined:
  - The MisalignW port is absent.
  - Low address bits below the access size are ignored (forced alignment), and the access proceeds.

## Structure
- riscv_pkg holds the Funct3 load/store encodings, the ResultSrc encodings and the mem_state_t enum {IDLE, WAIT}.
- One sub-module, load_extend: combinational lane select plus sign/zero extension (DRData, addr[1:0], funct3 -> 32-bit value).

## Test plan
- ALU op, ALUResultM=0x1234, RegWriteM=1, RdM=5 -> next edge ALUResultW=0x1234, RdW=5, ValidW=1, StallM never asserted.
- SB, addr 0x103, data 0xAB, ready=1 -> DAddr=0x100, DWStrb=1000, DWData=0xABABABAB, no stall.
- LB, addr 0x101, ready=1, response after 3 cycles with DRData=0x00008000 -> ReadDataW=0xFFFFFF80, StallM high exactly 3 cycles, bubbles in W meanwhile.
- LHU, addr 0x202, ready delayed 2 cycles -> DReqValid/DAddr stable for all 3 request cycles; DRData=0xBEEF0000 -> ReadDataW=0x0000BEEF.
- reset low while in WAIT, then DRspValid -> all outputs 0, FSM IDLE, response ignored.
- With macro: LW addr 0x102 -> no DReqValid, MisalignW=1, RegWriteW=0. Without macro: DAddr=0x100.
